joypad_target: RTL and testbench
================================

Name: joypad_target

Overview:
- Device-side (target) end of the two-wire joypad link.
- Sits on the controller board, or in a loopback test fabric, opposite the SoC's joypad bridge.
- Accepts START/address/pointer/read transactions on scl/sda and returns a coherent 4-byte register window of button state, MSB first.
- Open-drain sda is modelled as a separate sda_in and sda_out, with sda_out=1 meaning released.

Parameters:
- ADDR, 7'h52, 7-bit target address.
- DEV_ID, 8'hA5, value returned by register 2.
- DEBOUNCE_CYCLES, 16, stable-cycle count required before a button change is accepted (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- buttons  input  8  raw button levels, 1 = pressed; asynchronous to clk.
- scl_in  input  1  bus clock from the initiator.
- sda_in  input  1  bus data as seen on the wire.
- sda_out  output  1  0 = pull sda low, 1 = release.
- busy  output  1  high from an address-matched START until STOP or NACK-terminate.
- rd_strobe  output  1  one-cycle pulse when the register 0 byte is acknowledged by the initiator.

Behaviour:
- Input conditioning: scl_in, sda_in and buttons pass through 2-flop synchronizers. Edges are detected on the synchronized values, so the total input-to-edge latency is 3 clk cycles. Each scl half-period must be at least 8 clk cycles.
- Bus events (evaluated on synchronized signals):
  - START/repeated START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Data is sampled on scl rise. sda_out changes only in the cycle after a detected scl fall.
- Registers (index = 2-bit ptr):
  - 0 = snapshot of buttons.
  - 1 = sticky-pressed. A bit sets on a 0->1 transition of conditioned buttons. The register clears when its byte is ACKed by the initiator; a press occurring in that same cycle stays set.
  - 2 = DEV_ID.
  - 3 = transaction count: increments on each address match and wraps 255->0.
- State machine: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - ADDR: shifts 8 bits.
    - If addr[7:1]==ADDR: drive sda_out=0 after the 8th scl fall, enter ADDR_ACK, set busy, increment count.
    - Otherwise: enter IGNORE.
  - ADDR_ACK: release sda at the 9th scl fall.
    - Read (bit0=1): latch snapshot<=conditioned buttons, load shifter from reg[ptr], drive its MSB, enter RD_BYTE.
    - Write: enter WR_BYTE.
  - WR_BYTE: shifts 8 bits, then ACKs (WR_ACK).
    - The first data byte after the address sets ptr<=data[1:0].
    - Later data bytes are ACKed and discarded.
  - RD_BYTE: shift out 8 bits, then release sda for RD_ACK.
  - RD_ACK: sample the initiator's bit on the 9th scl rise.
    - 0 (ACK): ptr<=ptr+1 mod 4, load the next byte at the scl fall, return to RD_BYTE.
    - 1 (NACK): go to IGNORE, release sda, clear busy.
- Global event rules:
  - STOP in any state: -> IDLE, sda_out=1, busy=0, partial byte discarded; ptr is retained.
  - START in any state: -> ADDR. This takes precedence over all other transitions in the same cycle.
  - IGNORE holds sda_out=1 until START or STOP.
- Reset (synchronous, any state, including mid-byte):
  - State=IDLE, sda_out=1, busy=0, rd_strobe=0.
  - ptr=0, sticky=0, count=0, snapshot=0, synchronizers=0.
- Snapshot coherence: reg0 is frozen for the whole read burst. Live buttons do not affect any byte after ADDR_ACK.

Optional Feature:
- Macro: JOYPAD_TARGET_DEBOUNCE_EN.
- With the macro defined: each synchronized button has a counter, and the conditioned bit takes the new level only after DEBOUNCE_CYCLES consecutive cycles at that level. Any bounce restarts the counter.
- Without the macro: conditioned buttons = synchronized buttons, and no counters are synthesized.

Decomposition:
- Shared package holds:
  - State encoding constants.
  - Register index constants REG_BUTTONS=0, REG_STICKY=1, REG_ID=2, REG_COUNT=3.
  - Default address and ID values shared with the bridge.
- One natural sub-module: joypad_target_cond. It contains the button synchronizer, the optional debounce, and rising-edge/sticky set detection.

Test Plan:
- Reset/idle: assert rst mid-byte with sda_out=0 -> next cycle sda_out=1, busy=0; bus ignored until next START.
- Read burst: buttons=8'h81, write ptr=0, repeated START, read 4 bytes (ACK,ACK,ACK,NACK) -> 8'h81, sticky 8'h81, 8'hA5, count 8'h02. rd_strobe pulses once; busy drops after NACK.
- Snapshot coherence: buttons change 8'h01->8'h10 during byte 0 of a burst -> byte 0 returns 8'h01. The next transaction returns 8'h10, and the sticky register then reads 8'h11.
- Address mismatch: address 7'h53 -> no ACK (sda_out stays 1), count unchanged, IGNORE until STOP.
- Pointer wrap: write ptr=3, then read 2 bytes -> count value, then buttons (ptr wraps 3->0).
- Debounce (macro defined, DEBOUNCE_CYCLES=16): a 10-cycle glitch on buttons[0] -> reg0 bit0 stays 0. A 20-cycle press -> bit0 reads 1.

Source files
------------

// File: rtl/joypad_target_pkg.sv
// -----------------------------------------------------------------------------
// joypad_target_pkg
//   Shared definitions for the joypad link target and its SoC-side bridge:
//   FSM state encoding, register window indices and the default bus address
//   and device ID.
//
//   No ports (package).
// -----------------------------------------------------------------------------
package joypad_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    // Register window indices (2-bit pointer)
    localparam logic [1:0] REG_BUTTONS = 2'd0;
    localparam logic [1:0] REG_STICKY  = 2'd1;
    localparam logic [1:0] REG_ID      = 2'd2;
    localparam logic [1:0] REG_COUNT   = 2'd3;

    // Defaults shared with the initiator-side bridge
    localparam logic [6:0] JOYPAD_DEFAULT_ADDR   = 7'h52;
    localparam logic [7:0] JOYPAD_DEFAULT_DEV_ID = 8'hA5;

endpackage

// File: rtl/joypad_target_cond.sv
// -----------------------------------------------------------------------------
// joypad_target_cond
//   Button conditioning for the joypad target: 2-flop synchronizer, optional
//   per-button debounce, rising-edge detection and the sticky-pressed register.
//
//   Optional feature: define JOYPAD_TARGET_DEBOUNCE_EN to require
//   DEBOUNCE_CYCLES consecutive cycles at a new level before the conditioned
//   bit follows. Without it the conditioned value is the synchronized value.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   buttons    in   [7:0] raw button levels (asynchronous), 1 = pressed
//   sticky_clr in   clear sticky register this cycle (new presses still set)
//   cond       out  [7:0] conditioned button levels
//   sticky     out  [7:0] sticky-pressed register
// -----------------------------------------------------------------------------
module joypad_target_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] buttons,
    input  logic       sticky_clr,
    output logic [7:0] cond,
    output logic [7:0] sticky
);

    logic [7:0] btn_p0;
    logic [7:0] btn_p1;
    logic [7:0] cond_prev;
    logic [7:0] sticky_q;
    logic [7:0] press;

    // Stage p0/p1: two-flop synchronizer for asynchronous button inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= 8'd0;
            btn_p1 <= 8'd0;
        end else begin
            btn_p0 <= buttons;
            btn_p1 <= btn_p0;
        end
    end

`ifdef JOYPAD_TARGET_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [8];
    logic [7:0]       db_level;

    // A counter runs only while the synchronized level differs from the
    // accepted level; returning to the accepted level restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_level <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (btn_p1[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_level[i] <= btn_p1[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign cond = db_level;
`else
    assign cond = btn_p1;
`endif

    assign press = cond & ~cond_prev;

    // Clear and set may coincide: a press in the clearing cycle survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_prev <= 8'd0;
            sticky_q  <= 8'd0;
        end else begin
            cond_prev <= cond;
            sticky_q  <= (sticky_q & ~{8{sticky_clr}}) | press;
        end
    end

    assign sticky = sticky_q;

endmodule

// File: rtl/joypad_target.sv
// -----------------------------------------------------------------------------
// joypad_target
//   Target end of the two-wire joypad link. Responds to ADDR, accepts a
//   register pointer write and serves a 4-byte register window MSB first:
//   0 buttons snapshot, 1 sticky-pressed, 2 DEV_ID, 3 transaction count.
//   The snapshot is latched once per read so a burst is coherent.
//
//   Optional feature: JOYPAD_TARGET_DEBOUNCE_EN enables button debounce
//   (DEBOUNCE_CYCLES) inside joypad_target_cond.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   buttons    in   [7:0] raw button levels, 1 = pressed (asynchronous)
//   scl_in     in   bus clock from initiator
//   sda_in     in   bus data as seen on the wire
//   sda_out    out  0 = pull sda low, 1 = release
//   busy       out  address-matched transaction in progress
//   rd_strobe  out  one-cycle pulse when the register 0 byte is ACKed
// -----------------------------------------------------------------------------
module joypad_target
    import joypad_target_pkg::*;
#(
    parameter logic [6:0] ADDR            = JOYPAD_DEFAULT_ADDR,
    parameter logic [7:0] DEV_ID          = JOYPAD_DEFAULT_DEV_ID,
    parameter int         DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] buttons,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       busy,
    output logic       rd_strobe
);

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_out_q, sda_out_d;
    logic       busy_q, busy_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] count_q, count_d;
    logic [7:0] snapshot_q, snapshot_d;
    logic       first_wr_q, first_wr_d;
    logic       rd_strobe_q, rd_strobe_d;
    logic       sticky_clr;
    logic [7:0] cond_btn;
    logic [7:0] sticky;
    logic [7:0] first_load;

    joypad_target_cond #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cond (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .sticky_clr (sticky_clr),
        .cond       (cond_btn),
        .sticky     (sticky)
    );

    function automatic logic [7:0] reg_select(input logic [1:0] idx,
                                              input logic [7:0] btn_val,
                                              input logic [7:0] sticky_val,
                                              input logic [7:0] count_val);
        case (idx)
            REG_BUTTONS: reg_select = btn_val;
            REG_STICKY:  reg_select = sticky_val;
            REG_ID:      reg_select = DEV_ID;
            default:     reg_select = count_val;
        endcase
    endfunction

    // Stage p0/p1: synchronizers; p2 holds the previous synchronized value
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_p0 <= 1'b0;
            scl_p1 <= 1'b0;
            scl_p2 <= 1'b0;
            sda_p0 <= 1'b0;
            sda_p1 <= 1'b0;
            sda_p2 <= 1'b0;
        end else begin
            scl_p0 <= scl_in;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_in;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 & ~scl_p2;
    assign scl_fall  = ~scl_p1 & scl_p2;
    assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
    assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

    // The first read byte must see the snapshot being latched this cycle
    assign first_load = reg_select(ptr_q, cond_btn, sticky, count_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            sda_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            ptr_q       <= REG_BUTTONS;
            count_q     <= 8'd0;
            snapshot_q  <= 8'd0;
            first_wr_q  <= 1'b0;
            rd_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sda_out_q   <= sda_out_d;
            busy_q      <= busy_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            snapshot_q  <= snapshot_d;
            first_wr_q  <= first_wr_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sda_out_d   = sda_out_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        snapshot_d  = snapshot_q;
        first_wr_d  = first_wr_q;
        rd_strobe_d = 1'b0;
        sticky_clr  = 1'b0;

        if (start_det) begin
            // (Repeated) START wins over everything else in the same cycle
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_p1};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == ADDR) begin
                            state_d    = ST_ADDR_ACK;
                            sda_out_d  = 1'b0;
                            busy_d     = 1'b1;
                            count_d    = count_q + 8'd1;
                            first_wr_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // shift_q[0] still holds the R/W bit of the address byte
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            snapshot_d = cond_btn;
                            shift_d    = first_load;
                            sda_out_d  = first_load[7];
                            state_d    = ST_RD_BYTE;
                        end else begin
                            sda_out_d = 1'b1;
                            state_d   = ST_WR_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_p1};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = ST_WR_ACK;
                        sda_out_d = 1'b0;
                        if (first_wr_q) begin
                            ptr_d      = shift_q[1:0];
                            first_wr_d = 1'b0;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_out_d = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    // Count rises; each fall presents the next bit until 8 done
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_out_d = 1'b1;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_out_d = shift_q[6];
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_p1) begin
                            rd_strobe_d = (ptr_q == REG_BUTTONS);
                            sticky_clr  = (ptr_q == REG_STICKY);
                            ptr_d       = ptr_q + 2'd1;
                        end else begin
                            state_d   = ST_IGNORE;
                            sda_out_d = 1'b1;
                            busy_d    = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shift_d   = reg_select(ptr_q, snapshot_q, sticky, count_q);
                        sda_out_d = shift_d[7];
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RD_BYTE;
                    end
                end
                default: begin
                    // ST_IDLE and ST_IGNORE: wait for START/STOP with sda released
                    sda_out_d = 1'b1;
                end
            endcase
        end
    end

    assign sda_out   = sda_out_q;
    assign busy      = busy_q;
    assign rd_strobe = rd_strobe_q;

endmodule

// File: tb/tb_joypad_target.sv
module tb_joypad_target;

    localparam int H = 10;                 // scl half-period in clk cycles
    localparam logic [6:0] TADDR = 7'h52;

    logic       clk;
    logic       rst;
    logic [7:0] buttons;
    logic       scl_m;
    logic       sda_m;
    logic       sda_out;
    logic       busy;
    logic       rd_strobe;
    logic       sda_wire;

    assign sda_wire = sda_m & sda_out;

    joypad_target dut (
        .clk       (clk),
        .rst       (rst),
        .buttons   (buttons),
        .scl_in    (scl_m),
        .sda_in    (sda_wire),
        .sda_out   (sda_out),
        .busy      (busy),
        .rd_strobe (rd_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rs_cnt   = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) if (rd_strobe === 1'b1) rs_cnt++;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] btn;
        logic [1:0] ptr;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wclk(H);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b0; wclk(H);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wclk(2); sda_m = 1'b0; wclk(H);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b1; wclk(H);
    endtask

    task automatic write_bit(input logic b);
        wclk(2); sda_m = b; wclk(H - 2);
        scl_m = 1'b1; wclk(H);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wclk(2); sda_m = 1'b1; wclk(H - 2);
        scl_m = 1'b1; wclk(H - 1);
        @(negedge clk); b = sda_wire;
        @(posedge clk); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
    endtask

    // Pops one expected byte per byte read; last byte is NACKed
    task automatic read_bytes(input int n);
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_empty: got %0h, expected nothing queued", d);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rd_byte%0d", i), d, e);
            end
        end
    endtask

    task automatic set_ptr_and_read(input logic [1:0] p, input int n);
        logic ack;
        bus_start();
        send_byte({TADDR, 1'b0}, ack); check("addr_w_ack", ack, 1'b0);
        send_byte({6'd0, p}, ack);     check("ptr_ack", ack, 1'b0);
        bus_start();
        send_byte({TADDR, 1'b1}, ack); check("addr_r_ack", ack, 1'b0);
        read_bytes(n);
        bus_stop();
    endtask

    initial begin
        logic ack;
        int   rs0;

        tbl[0] = '{btn: 8'h81, ptr: 2'd2, exp0: 8'hA5, exp1: 8'h04};
        tbl[1] = '{btn: 8'h3C, ptr: 2'd1, exp0: 8'h3C, exp1: 8'hA5};
        tbl[2] = '{btn: 8'h3C, ptr: 2'd3, exp0: 8'h08, exp1: 8'h3C};
        tbl[3] = '{btn: 8'hFF, ptr: 2'd0, exp0: 8'hFF, exp1: 8'hC3};
        tbl[4] = '{btn: 8'h00, ptr: 2'd1, exp0: 8'hC3, exp1: 8'hA5};

        rst = 1'b1; buttons = 8'h00; scl_m = 1'b1; sda_m = 1'b1;
        wclk(5);
        @(negedge clk);
        check("rst_sda_out", sda_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_strobe", rd_strobe, 1'b0);
        @(posedge clk); rst = 1'b0;
        wclk(5);

        // Read burst from register 0
        buttons = 8'h81; wclk(10);
        rs0 = rs_cnt;
        bus_start();
        send_byte({TADDR, 1'b0}, ack); check("burst_addr_w_ack", ack, 1'b0);
        send_byte(8'h00, ack);         check("burst_ptr_ack", ack, 1'b0);
        bus_start();
        send_byte({TADDR, 1'b1}, ack); check("burst_addr_r_ack", ack, 1'b0);
        @(negedge clk); check("burst_busy_high", busy, 1'b1);
        exp_q.push_back(8'h81); exp_q.push_back(8'h81);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h02);
        read_bytes(4);
        @(negedge clk); check("burst_busy_after_nack", busy, 1'b0);
        check("burst_rd_strobe_pulses", 8'(rs_cnt - rs0), 8'd1);
        bus_stop();

        // Table-driven pointer/read transactions (includes 3->0 wrap)
        for (int i = 0; i < 5; i++) begin
            buttons = tbl[i].btn; wclk(10);
            exp_q.push_back(tbl[i].exp0);
            exp_q.push_back(tbl[i].exp1);
            set_ptr_and_read(tbl[i].ptr, 2);
        end

        // Snapshot coherence: buttons change during byte 0
        buttons = 8'h01; wclk(10);
        bus_start();
        send_byte({TADDR, 1'b0}, ack); check("coh_addr_w_ack", ack, 1'b0);
        send_byte(8'h00, ack);         check("coh_ptr_ack", ack, 1'b0);
        bus_start();
        send_byte({TADDR, 1'b1}, ack); check("coh_addr_r_ack", ack, 1'b0);
        fork
            begin wclk(50); buttons = 8'h10; end
        join_none
        exp_q.push_back(8'h01);
        read_bytes(1);
        bus_stop();
        exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        set_ptr_and_read(2'd0, 2);

        // Address mismatch, then IGNORE until STOP
        bus_start();
        send_byte({7'h53, 1'b0}, ack); check("mismatch_no_ack", ack, 1'b1);
        @(negedge clk); check("mismatch_busy", busy, 1'b0);
        send_byte({TADDR, 1'b0}, ack); check("ignore_no_ack", ack, 1'b1);
        bus_stop();
        exp_q.push_back(8'h12); exp_q.push_back(8'h10);
        set_ptr_and_read(2'd3, 2);

        // Reset mid-transaction while the target is pulling sda low
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(TADDR_BIT(i));
        wclk(2); sda_m = 1'b1; wclk(4);
        @(negedge clk);
        check("pre_rst_sda_low", sda_out, 1'b0);
        check("pre_rst_busy", busy, 1'b1);
        @(posedge clk); rst = 1'b1;
        @(posedge clk); rst = 1'b0;
        @(negedge clk);
        check("post_rst_sda_out", sda_out, 1'b1);
        check("post_rst_busy", busy, 1'b0);
        wclk(H);
        send_byte({TADDR, 1'b0}, ack); check("post_rst_ignored", ack, 1'b1);
        @(negedge clk); check("post_rst_busy_idle", busy, 1'b0);
        bus_stop();
        bus_start();
        send_byte({TADDR, 1'b1}, ack); check("post_rst_addr_r_ack", ack, 1'b0);
        exp_q.push_back(8'h10);
        read_bytes(1);
        bus_stop();
        exp_q.push_back(8'h03);
        set_ptr_and_read(2'd3, 1);

`ifdef JOYPAD_TARGET_DEBOUNCE_EN
        buttons = 8'h11; wclk(10); buttons = 8'h10; wclk(30);
        exp_q.push_back(8'h10);
        set_ptr_and_read(2'd0, 1);
        buttons = 8'h11; wclk(20);
        exp_q.push_back(8'h11);
        set_ptr_and_read(2'd0, 1);
`endif

        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic logic TADDR_BIT(input int i);
        logic [7:0] a;
        a = {TADDR, 1'b0};
        return a[i];
    endfunction

endmodule
